pdm_decimator: RTL and testbench
================================

Name: pdm_decimator

Overview:
- Consumes the divided microphone clock (mic_clk) produced by the clock divider, plus the 1-bit PDM stream returned by the MEMS microphone.
- Samples PDM bits on mic_clk rising edges and counts ones over fixed windows of DECIM bits (boxcar decimation).
- Pushes each window's count as an unsigned PCM sample into a small FWFT FIFO with a valid/ready output toward the audio/LED consumer.
- Runs entirely in the clk domain; mic_clk is treated as a data signal and edge-detected, never used as a clock.

Parameters:
- DECIM, 64: PDM bits per PCM sample; must be ≥2.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2: synchronizer flops on mic_clk and pdm_data; must be ≥2.
- Derived, not overridable: CNT_W = clog2(DECIM+1) (7 at default); LVL_W = clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high.
- en  in  1  capture enable; low discards the partial window.
- mic_clk  in  1  divided microphone clock from the divider.
- pdm_data  in  1  microphone PDM output.
- pcm_data  out  CNT_W  FIFO head sample (count of ones in the window).
- pcm_valid  out  1  FIFO non-empty.
- pcm_ready  in  1  consumer accepts the head when high with pcm_valid.
- fifo_level  out  LVL_W  current FIFO occupancy.
- overrun  out  1  sticky flag: a completed sample was dropped.

Behaviour:
- **Clock and reset:** clk is the only clock. reset is synchronous and active-high.
- **Reset values:**
  - All synchronizer flops, the previous-mic_clk register, bit_cnt and ones_acc go to 0.
  - FIFO is emptied; pcm_valid=0, pcm_data=0, fifo_level=0, overrun=0.
- **Synchronization:**
  - mic_clk and pdm_data each pass through SYNC_STAGES flops, so both carry equal delay.
  - mic_prev registers the synchronized mic_clk.
  - rise = mic_s & ~mic_prev (combinational).
- **Accumulation (en=1 and rise in cycle N):**
  - At the end of cycle N, ones_acc += pdm_s and bit_cnt += 1.
  - If bit_cnt==DECIM-1 in cycle N, the sample is complete:
    - push value = ones_acc + pdm_s (range 0..DECIM, no saturation needed);
    - ones_acc and bit_cnt clear to 0 on the same edge.
- **en=0:**
  - bit_cnt and ones_acc are held at 0; rise edges are ignored.
  - The FIFO keeps draining normally.
  - A new window starts on the first rise after en returns high.
- **FIFO behaviour:**
  - First-word fall-through: pcm_valid = !empty; pcm_data = head entry, or 0 when empty.
  - Pop occurs when pcm_valid & pcm_ready.
  - A push in the final-bit cycle N is written at the end of N. If the FIFO was empty, pcm_valid=1 in cycle N+1.
  - Latency from the mic_clk pin edge to pcm_valid is SYNC_STAGES+1 clk cycles, ±1 for input phase.
- **Full and overrun:**
  - Full with no pop in the same cycle: the completed sample is dropped and overrun is set. overrun clears only on reset.
  - Full with a pop in the same cycle: the push is accepted, level is unchanged, no overrun.
  - Empty with pcm_ready high: no pop, no underflow; read pointer unchanged.
- **Pointer and level rules:**
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_level is a separate counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- **Reset mid-window:** the partial window is discarded and the FIFO is flushed. The first sample after reset covers exactly DECIM fresh rises.
- **mic_clk stopped:** no rises occur, so no samples are produced; state is held indefinitely.

Decomposition:
- **Package pdm_pkg:**
  - default DECIM and FIFO_DEPTH constants;
  - clog2-based width helpers for CNT_W and LVL_W;
  - DECIM_DEFAULT/2 midpoint constant for downstream signed conversion.
- **Sub-module pdm_fifo:** synchronous FWFT FIFO with parameters WIDTH and DEPTH. Ports: push, push_data, pop, head, empty, full, level.
- **Top level:** synchronizers, edge detector, accumulator and overrun logic live in pdm_decimator.

Test Plan:
- **All ones:** mic_clk at 2.5 MHz square, pdm_data=1, en=1, pcm_ready=1 → every sample = 64; a sample every 64 mic_clk periods.
- **All zeros, then alternating:** pdm_data=0 → samples = 0. Then pdm_data toggled each mic_clk period → samples = 32.
- **Backpressure:** pcm_ready=0, all-ones, 5 windows → fifo_level=4, overrun=1, and the 5th sample is dropped. Then pcm_ready=1 → exactly 4 pops of value 64, after which pcm_valid=0.
- **Simultaneous push/pop when full:** FIFO full, pcm_ready pulses for 1 cycle in the same cycle as a window completes → level stays 4, overrun stays 0, new sample lands at the tail.
- **Reset and en mid-window:**
  - reset asserted after 30 rises → all outputs at reset values; the next sample counts exactly 64 post-reset rises.
  - en dropped after 20 rises, then raised → the first sample reflects only post-enable bits (all-ones → 64).
- **Latency:** a single window with the FIFO empty → pcm_valid rises exactly 1 clk after the cycle where rise coincides with bit_cnt==63. pcm_data is stable until popped.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM decimator slice.
// Imported by pdm_fifo and pdm_decimator.
package pdm_pkg;

  localparam int DECIM_DEFAULT       = 64;
  localparam int FIFO_DEPTH_DEFAULT  = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Midpoint of the default window, used downstream to turn
  // a ones-count into a signed PCM value.
  localparam int PCM_MID = DECIM_DEFAULT / 2;

  function automatic int cnt_width(input int decim);
    return $clog2(decim + 1);
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pdm_fifo.sv
// Synchronous first-word-fall-through FIFO for PCM samples.
// Ports: clk, reset, push/push_data, pop, head, empty, full, level.
module pdm_fifo
  import pdm_pkg::*;
#(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a push
  // into a full FIFO is accepted when a pop coincides.
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign head  = w_empty ? '0 : r_mem[r_rptr];
  assign empty = w_empty;
  assign full  = w_full;
  assign level = r_level;

endmodule

// File: rtl/pdm_decimator.sv
// Boxcar PDM-to-PCM decimator: counts ones over DECIM mic_clk rises.
// Ports: clk, reset, en, mic_clk, pdm_data in; pcm_* stream, fifo_level, overrun out.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter  int DECIM       = DECIM_DEFAULT,
  parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  localparam int CNT_W       = cnt_width(DECIM),
  localparam int LVL_W       = lvl_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mic_clk,
  input  logic             pdm_data,
  output logic [CNT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overrun
);

  logic [SYNC_STAGES-1:0] r_mic_sync;
  logic [SYNC_STAGES-1:0] r_pdm_sync;
  logic                   r_mic_prev;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [CNT_W-1:0]       r_ones_acc;
  logic                   r_overrun;

  logic             w_mic_s;
  logic             w_pdm_s;
  logic             w_rise;
  logic             w_last;
  logic             w_complete;
  logic [CNT_W-1:0] w_sample;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic [CNT_W-1:0] w_head;

  // Both inputs go through identical chains so the data bit
  // stays aligned with the edge that qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mic_sync <= '0;
      r_pdm_sync <= '0;
      r_mic_prev <= 1'b0;
    end else begin
      r_mic_sync <= {r_mic_sync[SYNC_STAGES-2:0], mic_clk};
      r_pdm_sync <= {r_pdm_sync[SYNC_STAGES-2:0], pdm_data};
      r_mic_prev <= w_mic_s;
    end
  end

  assign w_mic_s = r_mic_sync[SYNC_STAGES-1];
  assign w_pdm_s = r_pdm_sync[SYNC_STAGES-1];
  assign w_rise  = w_mic_s & ~r_mic_prev;

  assign w_last     = (r_bit_cnt == CNT_W'(DECIM - 1));
  assign w_complete = en & w_rise & w_last;
  assign w_sample   = r_ones_acc + CNT_W'(w_pdm_s);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_bit_cnt  <= '0;
      r_ones_acc <= '0;
    end else if (w_rise) begin
      if (w_last) begin
        r_bit_cnt  <= '0;
        r_ones_acc <= '0;
      end else begin
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        r_ones_acc <= w_sample;
      end
    end
  end

  assign w_pop = ~w_empty & pcm_ready;

  // A completed sample is lost only when the FIFO is full
  // and nothing leaves it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_complete & w_full & ~w_pop) begin
      r_overrun <= 1'b1;
    end
  end

  pdm_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_complete),
    .push_data (w_sample),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .level     (fifo_level)
  );

  assign pcm_data  = w_head;
  assign pcm_valid = ~w_empty;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator with a window/queue reference model.
// Drives mic_clk at 2.5 MHz (40 clk cycles) and random or patterned PDM bits.
module tb_pdm_decimator;

  localparam int DECIM = 64;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mic_clk = 1'b0;
  logic       pdm_data = 1'b0;
  logic       pcm_ready = 1'b0;
  logic [6:0] pcm_data;
  logic       pcm_valid;
  logic [2:0] fifo_level;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int q[$];
  int win_n = 0;
  int win_ones = 0;
  bit pop_same = 0;
  int pop_cnt = 0;
  int last_pop = -1;
  int p0;

  pdm_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mic_clk    (mic_clk),
    .pdm_data   (pdm_data),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .fifo_level (fifo_level),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference: a window is DECIM enabled rises; its sample is the
  // number of ones seen. Samples queue up to DEPTH entries.
  task automatic model_rise();
    if (!en) begin
      win_n = 0;
      win_ones = 0;
      return;
    end
    win_ones += int'(pdm_data);
    win_n++;
    if (win_n == DECIM) begin
      if (q.size() < DEPTH || pop_same) q.push_back(win_ones);
      win_n = 0;
      win_ones = 0;
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (!reset && pcm_valid === 1'b1 && pcm_ready === 1'b1) begin
      pop_cnt++;
      last_pop = int'(pcm_data);
      e = (q.size() != 0) ? q.pop_front() : -1;
      chk("pop_data", 32'(pcm_data), e);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mic_low(bit b);
    pdm_data = b;
    mic_clk = 1'b0;
    cyc(HALF);
  endtask

  task automatic mic_high();
    mic_clk = 1'b1;
    model_rise();
    cyc(HALF);
  endtask

  function automatic bit gen(int mode, int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return i[0];
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic send_bits(int mode, int n);
    for (int i = 0; i < n; i++) begin
      mic_low(gen(mode, i));
      mic_high();
    end
  endtask

  task automatic do_reset();
    mic_clk = 1'b0;
    cyc(4);
    reset = 1'b1;
    q.delete();
    win_n = 0;
    win_ones = 0;
    cyc(3);
    chk("rst_valid", 32'(pcm_valid), 0);
    chk("rst_data", 32'(pcm_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    cyc(2);
  endtask

  // Final rise of a window with cycle-exact observation: the rise is
  // seen SYNC_STAGES edges after the pin, the push lands one edge later.
  task automatic last_bit_timed(bit b, bit pulse, bit lat);
    mic_low(b);
    mic_clk = 1'b1;
    pop_same = pulse;
    model_rise();
    pop_same = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (lat) chk("lat_pre_valid", 32'(pcm_valid), 0);
    if (pulse) pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) pcm_ready = 1'b0;
    if (lat) chk("lat_valid", 32'(pcm_valid), 1);
    cyc(HALF - 3);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cyc(3);
    chk("init_valid", 32'(pcm_valid), 0);
    chk("init_data", 32'(pcm_data), 0);
    chk("init_level", 32'(fifo_level), 0);
    chk("init_overrun", 32'(overrun), 0);
    reset = 1'b0;
    en = 1'b1;
    pcm_ready = 1'b1;
    cyc(2);

    send_bits(1, DECIM);
    chk("ones_1", last_pop, 64);
    send_bits(1, DECIM);
    chk("ones_2", last_pop, 64);
    chk("ones_cnt", pop_cnt, 2);

    send_bits(0, DECIM);
    chk("zeros", last_pop, 0);
    send_bits(2, DECIM);
    chk("alternate", last_pop, 32);

    repeat (3) send_bits(3, DECIM);
    chk("rand_cnt", pop_cnt, 7);

    pcm_ready = 1'b0;
    p0 = pop_cnt;
    repeat (5) send_bits(1, DECIM);
    chk("bp_level", 32'(fifo_level), 4);
    chk("bp_model_level", 32'(fifo_level), q.size());
    chk("bp_overrun", 32'(overrun), 1);
    chk("bp_head", 32'(pcm_data), 64);
    pcm_ready = 1'b1;
    cyc(10);
    chk("bp_pops", pop_cnt - p0, 4);
    chk("bp_empty", 32'(pcm_valid), 0);
    chk("bp_level0", 32'(fifo_level), 0);
    chk("bp_sticky", 32'(overrun), 1);

    do_reset();
    pcm_ready = 1'b0;
    repeat (4) send_bits(3, DECIM);
    chk("full_level", 32'(fifo_level), 4);
    send_bits(3, DECIM - 1);
    p0 = pop_cnt;
    last_bit_timed(1'($urandom % 2), 1'b1, 1'b0);
    chk("sim_level", 32'(fifo_level), 4);
    chk("sim_overrun", 32'(overrun), 0);
    chk("sim_pops", pop_cnt - p0, 1);
    pcm_ready = 1'b1;
    cyc(10);
    chk("sim_drain", pop_cnt - p0, 5);

    send_bits(0, 30);
    do_reset();
    p0 = pop_cnt;
    send_bits(1, DECIM);
    chk("rst_sample", last_pop, 64);
    chk("rst_pops", pop_cnt - p0, 1);

    send_bits(0, 20);
    en = 1'b0;
    cyc(5);
    send_bits(1, 10);
    en = 1'b1;
    p0 = pop_cnt;
    send_bits(1, DECIM);
    chk("en_sample", last_pop, 64);
    chk("en_pops", pop_cnt - p0, 1);

    pcm_ready = 1'b0;
    send_bits(1, DECIM - 1);
    last_bit_timed(1'b1, 1'b0, 1'b1);
    chk("lat_head", 32'(pcm_data), 64);
    chk("lat_level", 32'(fifo_level), 1);
    cyc(10);
    chk("lat_stable", 32'(pcm_data), 64);
    p0 = pop_cnt;
    pcm_ready = 1'b1;
    cyc(3);
    chk("lat_pops", pop_cnt - p0, 1);
    chk("lat_empty", 32'(pcm_valid), 0);
    chk("lat_data0", 32'(pcm_data), 0);

    p0 = pop_cnt;
    cyc(300);
    chk("idle_pops", pop_cnt - p0, 0);
    chk("idle_level", 32'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
